// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM state type for the 16/16 signed divider.
package div_pkg;

    localparam int DIV_W  = 16;
    localparam int CNT_W  = 5;
    localparam int ITER_N = 16;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W:0]   remIn,
    input  logic             bitIn,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W:0]   remOut,
    output logic             qBit
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] trial;

    // A set top bit means the shifted value already exceeds any 16-bit divisor.
    always_comb begin
        shifted = {remIn[DIV_W-1:0], bitIn};
        trial   = shifted - {1'b0, divisor};
        qBit    = remIn[DIV_W] | (shifted >= {1'b0, divisor});
        remOut  = qBit ? trial : shifted;
    end

endmodule

// File: rtl/div_tc_16_16.sv
// Multi-cycle truncating signed 16/16 divider with valid/ready handshakes.
// Define DIV_ZERO_EARLY_EN to let a zero divisor skip the iteration phase.
module div_tc_16_16
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   aCap_q, aCap_d, bCap_q, bCap_d;
    logic               signA_q, signA_d, signB_q, signB_d;
    logic [DIV_W-1:0]   dividend_q, dividend_d, divisor_q, divisor_d;
    logic [DIV_W:0]     rem_q, rem_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   quotient_q, quotient_d, remainder_q, remainder_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d;
    logic [DIV_W:0]     stepRem;
    logic               stepBit;

    div_step uStep (
        .remIn   (rem_q),
        .bitIn   (dividend_q[DIV_W-1]),
        .divisor (divisor_q),
        .remOut  (stepRem),
        .qBit    (stepBit)
    );

    assign in_ready    = (state_q == IDLE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

`ifdef DIV_ZERO_EARLY_EN
    // The early exit reaches DONE one edge ahead of its advertised latency.
    logic holdValid_q, holdValid_d;
    assign out_valid = (state_q == DONE) && !holdValid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) holdValid_q <= 1'b0;
        else     holdValid_q <= holdValid_d;
    end
`else
    assign out_valid = (state_q == DONE);
`endif

    always_comb begin
        state_d     = state_q;
        aCap_d      = aCap_q;
        bCap_d      = bCap_q;
        signA_d     = signA_q;
        signB_d     = signB_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
`ifdef DIV_ZERO_EARLY_EN
        holdValid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aCap_d  = a;
                    bCap_d  = b;
                    signA_d = a[DIV_W-1];
                    signB_d = b[DIV_W-1];
                    state_d = PREP;
                end
            end
            PREP: begin
                dividend_d = signA_q ? (~aCap_q + 1'b1) : aCap_q;
                divisor_d  = signB_q ? (~bCap_q + 1'b1) : bCap_q;
                rem_d      = '0;
                quo_d      = '0;
                cnt_d      = '0;
                state_d    = ITER;
`ifdef DIV_ZERO_EARLY_EN
                if (bCap_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = aCap_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    holdValid_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            ITER: begin
                rem_d      = stepRem;
                quo_d      = {quo_q[DIV_W-2:0], stepBit};
                dividend_d = {dividend_q[DIV_W-2:0], 1'b0};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER_N - 1)) state_d = FIX;
            end
            FIX: begin
                // 0x8000 / -1 needs no special case: negating 0x8000 wraps to itself.
                quotient_d  = (signA_q ^ signB_q) ? (~quo_q + 1'b1) : quo_q;
                remainder_d = signA_q ? (~rem_q[DIV_W-1:0] + 1'b1) : rem_q[DIV_W-1:0];
                dbz_d       = 1'b0;
                ovf_d       = (aCap_q == 16'h8000) && (bCap_q == 16'hFFFF);
                if (bCap_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = aCap_q;
                    dbz_d       = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            aCap_q      <= '0;
            bCap_q      <= '0;
            signA_q     <= 1'b0;
            signB_q     <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            aCap_q      <= aCap_d;
            bCap_q      <= bCap_d;
            signA_q     <= signA_d;
            signB_q     <= signB_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_div_tc_16_16.sv
// Directed and randomized bench for div_tc_16_16 against an integer-arithmetic reference.
module tb_div_tc_16_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

`ifdef DIV_ZERO_EARLY_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 18;
`endif

    div_tc_16_16 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truncating signed division expressed with plain integer operators.
    function automatic void refDiv(input logic [15:0] av, input logic [15:0] bv,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dz, output logic ov);
        int sa;
        int sb;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 16'hFFFF;
            r  = av;
            dz = 1'b1;
        end else if (sa == -32768 && sb == -1) begin
            q  = 16'h8000;
            r  = 16'h0000;
            ov = 1'b1;
        end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end
    endfunction

    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input int holdCycles);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ed;
        logic        eo;
        int          lat;
        int          expLat;
        refDiv(av, bv, eq, er, ed, eo);
        expLat = (bv == 16'h0000) ? ZERO_LAT : 18;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        checkOutput("inReadyIdle", 32'(in_ready), 32'd1);
        @(negedge clk);
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = (holdCycles == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat      = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        if (lat == 0) return;
        checkOutput("quotient", 32'(quotient), 32'(eq));
        checkOutput("remainder", 32'(remainder), 32'(er));
        checkOutput("divByZero", 32'(div_by_zero), 32'(ed));
        checkOutput("overflow", 32'(overflow), 32'(eo));
        checkOutput("inReadyBusy", 32'(in_ready), 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdQuotient", 32'(quotient), 32'(eq));
            checkOutput("holdRemainder", 32'(remainder), 32'(er));
            checkOutput("holdFlags", {30'd0, div_by_zero, overflow}, {30'd0, ed, eo});
            checkOutput("holdInReady", 32'(in_ready), 32'd0);
        end
        if (holdCycles > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("validDropped", 32'(out_valid), 32'd0);
        checkOutput("inReadyAfter", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        checkOutput("rstQuotient", 32'(quotient), 32'd0);
        checkOutput("rstRemainder", 32'(remainder), 32'd0);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstFlags", {30'd0, div_by_zero, overflow}, 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'd100, 16'd7, 0);
        applyStimulus(16'hFF9C, 16'd7, 5);
        applyStimulus(16'd100, 16'hFFF9, 0);
        applyStimulus(16'h8000, 16'hFFFF, 0);
        applyStimulus(16'h8000, 16'h0001, 2);
        applyStimulus(16'h1234, 16'h0000, 0);
        applyStimulus(16'h8000, 16'h0000, 1);
        applyStimulus(16'h7FFF, 16'h8000, 0);

        // Reset in the middle of an operation must discard it.
        @(negedge clk);
        a        = 16'd500;
        b        = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        begin
            int seenValid;
            seenValid = 0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seenValid++;
            end
            checkOutput("discardedOp", 32'(seenValid), 32'd0);
        end
        applyStimulus(16'd9, 16'd3, 0);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 16'h0000;
            if ($urandom_range(0, 7) == 0) rb = 16'($urandom_range(1, 5));
            applyStimulus(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_tc_16_16.md
DIV_TC_16_16 -- requirements
Module: div_tc_16_16

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1; operands a/b are valid this cycle.
REQ-004 SHALL have port in_ready, output, 1; block can accept operands (high only in IDLE).
REQ-005 SHALL have port a, input, 16; dividend, two's complement.
REQ-006 SHALL have port b, input, 16; divisor, two's complement.
REQ-007 SHALL have port out_valid, output, 1; result registers hold a valid result.
REQ-008 SHALL have port out_ready, input, 1; consumer accepts the result.
REQ-009 SHALL have port quotient, output, 16; signed quotient.
REQ-010 SHALL have port remainder, output, 16; signed remainder.
REQ-011 SHALL have port div_by_zero, output, 1; set when b==0 for the held result.
REQ-012 SHALL have port overflow, output, 1; set when a==0x8000 and b==0xFFFF for the held result.

Function
REQ-013 SHALL compute truncating signed division: quotient rounds toward zero, remainder takes the sign of a, a == quotient*b + remainder (mod 2^16).
REQ-014 SHALL use FSM states IDLE, PREP, ITER, FIX, DONE.
REQ-015 SHALL accept operands on edge T0 when in_valid&&in_ready; IDLE->PREP; a, b and both sign bits are captured.
REQ-016 PREP SHALL form 16-bit unsigned magnitudes |a| and |b| (0x8000 maps to 32768), clear the 5-bit counter, then enter ITER.
REQ-017 ITER SHALL run one radix-2 restoring step per cycle for exactly 16 cycles, MSB first; a 17-bit partial remainder holds the trial subtract.
REQ-018 FIX SHALL negate the quotient if sign(a)^sign(b), negate the remainder if sign(a), register the flags, then enter DONE.
REQ-019 SHALL assert out_valid from edge T0+18 (normal path) until the edge on which out_valid&&out_ready; DONE->IDLE on that edge.
REQ-020 quotient/remainder/flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 in_ready SHALL be 0 in PREP/ITER/FIX/DONE; in_valid is ignored there; no back-to-back overlap.
REQ-022 b==0 SHALL yield quotient=0xFFFF, remainder=a, div_by_zero=1, overflow=0.
REQ-023 a==0x8000, b==0xFFFF SHALL yield quotient=0x8000, remainder=0x0000, overflow=1.
REQ-024 For all other operands, div_by_zero=0 and overflow=0.
REQ-025 When out_ready is already high as out_valid rises, the handshake completes in that cycle (single-cycle out_valid pulse).

Reset
REQ-026 rst high SHALL force IDLE immediately, regardless of clk.
REQ-027 Reset values: quotient=0, remainder=0, out_valid=0, div_by_zero=0, overflow=0, in_ready=1.
REQ-028 Reset during PREP/ITER/FIX/DONE SHALL discard the operation; no out_valid is produced for it.

Configuration
REQ-029 Macro DIV_ZERO_EARLY_EN: when defined, b==0 detected in PREP SHALL go PREP->DONE directly, with out_valid at T0+2 and the results of REQ-022.
REQ-030 Without DIV_ZERO_EARLY_EN, b==0 SHALL take the full PREP/ITER/FIX path (out_valid at T0+18); FIX overrides the results to REQ-022 values.

Structure
REQ-031 Package div_pkg SHALL hold DIV_W=16, CNT_W=5, ITER_N=16 and the FSM state enum typedef.
REQ-032 Sub-module div_step SHALL hold one combinational restoring step: inputs partial remainder, next dividend bit, |b|; outputs new remainder and quotient bit. It is instantiated once and reused across the ITER cycles.

Verification
REQ-033 a=100, b=7, out_ready=1 -> quotient=14, remainder=2, out_valid pulses at T0+18, flags 0.
REQ-034 a=-100 (0xFF9C), b=7 -> quotient=-14 (0xFFF2), remainder=-2 (0xFFFE); a=100, b=-7 -> quotient=0xFFF2, remainder=2.
REQ-035 a=0x8000, b=0xFFFF -> quotient=0x8000, remainder=0, overflow=1; a=0x8000, b=1 -> quotient=0x8000, remainder=0, overflow=0.
REQ-036 a=0x1234, b=0 -> quotient=0xFFFF, remainder=0x1234, div_by_zero=1; out_valid at T0+2 with the macro, T0+18 without.
REQ-037 out_ready held 0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; after the handshake, in_ready=1 on the next cycle.
REQ-038 rst pulsed at T0+8 -> out_valid stays 0, in_ready=1 immediately, and the next operation a=9, b=3 gives quotient=3, remainder=0.
